// File: rtl/wash_dispatch_scheduler_pkg.sv
// Shared types and default constants for the washer dispatch scheduler.
package wash_sched_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      SETTLE = 2'd2
   } sched_state_e;

   localparam int PRICE_SINGLE_DEF = 2;
   localparam int PRICE_DOUBLE_DEF = 3;
   localparam int CREDIT_W_DEF     = 5;
   localparam int CREDIT_MAX_DEF   = (1 << CREDIT_W_DEF) - 1;

endpackage

// File: rtl/wash_dispatch_scheduler_rr_pick.sv
// Combinational round-robin picker: first eligible index at or after the pointer, wrapping.
module rr_pick #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  i_eligible,
   input  logic [IW-1:0] i_ptr,
   output logic          o_valid,
   output logic [IW-1:0] o_index
);

   localparam logic [IW:0] N_L = (IW+1)'(N);

   logic [IW:0]   w_sum;
   logic [IW-1:0] w_idx;

   // Scan from the farthest offset down so the nearest eligible index wins.
   always_comb begin
      o_valid = 1'b0;
      o_index = '0;
      w_sum   = '0;
      w_idx   = '0;
      for (int k = N - 1; k >= 0; k--) begin
         w_sum = {1'b0, i_ptr} + (IW+1)'(k);
         if (w_sum >= N_L) w_sum = w_sum - N_L;
         w_idx = w_sum[IW-1:0];
         if (i_eligible[w_idx]) begin
            o_valid = 1'b1;
            o_index = w_idx;
         end
      end
   end

endmodule

// File: rtl/wash_dispatch_scheduler.sv
// Coin-credit scheduler: grants one idle requesting washer round-robin, charges it, pulses start.
//  state  | meaning
//  IDLE   | waiting for an eligible washer; grant index and double flag latched on exit
//  LAUNCH | charge credit, pulse start, mark washer busy, advance round-robin pointer
//  SETTLE | start pulse visible; one dead cycle so starts are never back-to-back
module wash_dispatch_scheduler
   import wash_sched_pkg::*;
#(
   parameter int NUM_WASHERS  = 4,
   parameter int CREDIT_W     = CREDIT_W_DEF,
   parameter int PRICE_SINGLE = PRICE_SINGLE_DEF,
   parameter int PRICE_DOUBLE = PRICE_DOUBLE_DEF
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_coin_pulse,
   input  logic [NUM_WASHERS-1:0] i_req,
   input  logic [NUM_WASHERS-1:0] i_req_double,
   input  logic [NUM_WASHERS-1:0] i_wash_done,
   output logic [NUM_WASHERS-1:0] o_start,
   output logic [NUM_WASHERS-1:0] o_double_wash,
   output logic [NUM_WASHERS-1:0] o_busy,
   output logic [CREDIT_W-1:0]    o_credit,
   output logic                   o_credit_full
);

   localparam int                IW    = $clog2(NUM_WASHERS);
   localparam logic [CREDIT_W-1:0] P_SGL = CREDIT_W'(PRICE_SINGLE);
   localparam logic [CREDIT_W-1:0] P_DBL = CREDIT_W'(PRICE_DOUBLE);
   localparam logic [CREDIT_W-1:0] C_MAX = '1;
   localparam logic [IW-1:0]       LAST  = IW'(NUM_WASHERS - 1);

   sched_state_e            r_state, w_state_nxt;
   logic [IW-1:0]           r_grant, r_rr_ptr, w_pick_idx;
   logic                    r_grant_dbl, w_pick_valid, w_latch, w_launch;
   logic [NUM_WASHERS-1:0]  r_start, r_busy, r_dbl, r_done_q;
   logic [NUM_WASHERS-1:0]  w_elig, w_grant_oh, w_done_rise;
   logic [CREDIT_W-1:0]     r_credit, w_charge, w_price, w_credit_nxt;
   logic [CREDIT_W:0]       w_credit_sum;
   logic                    r_full;

   always_comb begin
      w_elig  = '0;
      w_price = '0;
      for (int i = 0; i < NUM_WASHERS; i++) begin
         w_price   = i_req_double[i] ? P_DBL : P_SGL;
         w_elig[i] = i_req[i] & ~r_busy[i] & (r_credit >= w_price);
      end
   end

   rr_pick #(.N(NUM_WASHERS), .IW(IW)) u_rr_pick (
      .i_eligible (w_elig),
      .i_ptr      (r_rr_ptr),
      .o_valid    (w_pick_valid),
      .o_index    (w_pick_idx)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE:    if (w_pick_valid) w_state_nxt = LAUNCH;
         LAUNCH:  w_state_nxt = SETTLE;
         SETTLE:  w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      w_latch    = (r_state == IDLE) && w_pick_valid;
      w_launch   = (r_state == LAUNCH);
      w_charge   = '0;
      w_grant_oh = '0;
      if (w_launch) begin
         w_charge            = r_grant_dbl ? P_DBL : P_SGL;
         w_grant_oh[r_grant] = 1'b1;
      end
   end

   // Charge never exceeds credit, so the extra sum bit only flags coin overflow.
   assign w_credit_sum = {1'b0, r_credit} + {{CREDIT_W{1'b0}}, i_coin_pulse} - {1'b0, w_charge};
   assign w_credit_nxt = w_credit_sum[CREDIT_W] ? C_MAX : w_credit_sum[CREDIT_W-1:0];
   assign w_done_rise  = i_wash_done & ~r_done_q;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_done_q    <= '0;
         r_credit    <= '0;
         r_full      <= 1'b0;
         r_start     <= '0;
         r_busy      <= '0;
         r_dbl       <= '0;
         r_grant     <= '0;
         r_grant_dbl <= 1'b0;
         r_rr_ptr    <= '0;
      end else begin
         r_done_q <= i_wash_done;
         r_credit <= w_credit_nxt;
         r_full   <= (w_credit_nxt == C_MAX);
         r_start  <= w_grant_oh;
         r_busy   <= (r_busy & ~w_done_rise) | w_grant_oh;
         r_dbl    <= (r_dbl & ~w_done_rise & ~w_grant_oh) | (r_grant_dbl ? w_grant_oh : '0);
         if (w_latch) begin
            r_grant     <= w_pick_idx;
            r_grant_dbl <= i_req_double[w_pick_idx];
         end
         if (w_launch) r_rr_ptr <= (r_grant == LAST) ? '0 : r_grant + IW'(1);
      end
   end

   assign o_start       = r_start;
   assign o_double_wash = r_dbl;
   assign o_busy        = r_busy;
   assign o_credit      = r_credit;
   assign o_credit_full = r_full;

endmodule

// File: tb/tb_wash_dispatch_scheduler.sv
// Scoreboard bench: expected starts are queued by stimulus and checked when the DUT pulses start.
module tb_wash_dispatch_scheduler;

   localparam int N  = 4;
   localparam int CW = 5;

   logic          i_clk = 1'b0;
   logic          i_rst = 1'b1;
   logic          i_coin_pulse = 1'b0;
   logic [N-1:0]  i_req = '0;
   logic [N-1:0]  i_req_double = '0;
   logic [N-1:0]  i_wash_done = '0;
   logic [N-1:0]  o_start, o_double_wash, o_busy;
   logic [CW-1:0] o_credit;
   logic          o_credit_full;

   wash_dispatch_scheduler #(
      .NUM_WASHERS(N), .CREDIT_W(CW), .PRICE_SINGLE(2), .PRICE_DOUBLE(3)
   ) dut (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .i_coin_pulse  (i_coin_pulse),
      .i_req         (i_req),
      .i_req_double  (i_req_double),
      .i_wash_done   (i_wash_done),
      .o_start       (o_start),
      .o_double_wash (o_double_wash),
      .o_busy        (o_busy),
      .o_credit      (o_credit),
      .o_credit_full (o_credit_full)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      int   idx;
      logic dbl;
      int   credit;
      int   cyc;
   } exp_t;

   exp_t         sb[$];
   exp_t         e;
   int           n_tests = 0;
   int           n_fail  = 0;
   int           cyc     = 0;
   logic [N-1:0] prev_start = '0;

   always @(posedge i_clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic coins(input int n);
      i_coin_pulse = 1'b1;
      repeat (n) tick();
      i_coin_pulse = 1'b0;
   endtask

   task automatic push(input int idx, input logic dbl, input int credit, input int c);
      exp_t x;
      x.idx = idx; x.dbl = dbl; x.credit = credit; x.cyc = c;
      sb.push_back(x);
   endtask

   task automatic wait_sb(input int budget);
      int k = 0;
      while (sb.size() != 0 && k < budget) begin
         tick();
         k++;
      end
      if (sb.size() != 0) begin
         chk("start_timeout_pending", 32'(sb.size()), 0);
         sb.delete();
      end
   endtask

   task automatic do_reset();
      i_rst = 1'b1;
      i_req = '0; i_req_double = '0; i_wash_done = '0; i_coin_pulse = 1'b0;
      tick();
      tick();
      i_rst = 1'b0;
      tick();
   endtask

   // Monitor: every start pulse must match the head of the scoreboard.
   initial forever begin
      @(negedge i_clk);
      if (o_start != '0) begin
         chk("start_single_cycle", 32'(prev_start), 0);
         if (sb.size() == 0) begin
            chk("unexpected_start", 32'(o_start), 0);
         end else begin
            e = sb.pop_front();
            chk("start_index", 32'(o_start), 32'(1) << e.idx);
            chk("double_at_start", 32'(o_double_wash[e.idx]), 32'(e.dbl));
            chk("credit_at_start", 32'(o_credit), 32'(e.credit));
            chk("busy_at_start", 32'(o_busy[e.idx]), 1);
            if (e.cyc >= 0) chk("start_latency", 32'(cyc), 32'(e.cyc));
         end
      end
      prev_start = o_start;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset state
      tick();
      chk("rst_start", 32'(o_start), 0);
      chk("rst_busy", 32'(o_busy), 0);
      chk("rst_double", 32'(o_double_wash), 0);
      chk("rst_credit", 32'(o_credit), 0);
      chk("rst_full", 32'(o_credit_full), 0);
      i_rst = 1'b0;
      tick();

      // 1: two coins, single wash on washer 1, latency two clocks
      coins(2);
      chk("t1_credit_before", 32'(o_credit), 2);
      push(1, 1'b0, 0, cyc + 2);
      i_req = 4'b0010;
      wait_sb(10);
      i_req = '0;
      chk("t1_busy", 32'(o_busy), 2);
      chk("t1_credit", 32'(o_credit), 0);
      chk("t1_start_low", 32'(o_start), 0);

      // 2: round-robin over 0,1,3 with exactly enough credit
      do_reset();
      coins(6);
      push(0, 1'b0, 4, -1);
      push(1, 1'b0, 2, -1);
      push(3, 1'b0, 0, -1);
      i_req = 4'b1011;
      wait_sb(30);
      i_req = '0;
      chk("t2_credit", 32'(o_credit), 0);
      chk("t2_busy", 32'(o_busy), 11);

      // 3: double wash blocked at credit 2, granted at 3; later req/double changes ignored
      do_reset();
      coins(2);
      i_req_double = 4'b0100;
      i_req = 4'b0100;
      repeat (6) tick();
      chk("t3_no_grant_busy", 32'(o_busy), 0);
      chk("t3_credit_held", 32'(o_credit), 2);
      push(2, 1'b1, 0, -1);
      coins(1);
      tick();
      i_req = '0;
      i_req_double = '0;
      wait_sb(10);
      chk("t3_double", 32'(o_double_wash), 4);
      chk("t3_busy", 32'(o_busy), 4);

      // 4: done rising edge clears busy/double; held level does not clear again
      do_reset();
      coins(3);
      i_req_double = 4'b0001;
      i_req = 4'b0001;
      push(0, 1'b1, 0, -1);
      wait_sb(10);
      i_req = '0;
      i_req_double = '0;
      chk("t4_busy_set", 32'(o_busy), 1);
      chk("t4_double_set", 32'(o_double_wash), 1);
      i_wash_done = 4'b0001;
      tick();
      chk("t4_busy_cleared", 32'(o_busy), 0);
      chk("t4_double_cleared", 32'(o_double_wash), 0);
      coins(2);
      i_req = 4'b0001;
      push(0, 1'b0, 0, -1);
      wait_sb(10);
      i_req = '0;
      repeat (3) tick();
      chk("t4_held_done_no_clear", 32'(o_busy), 1);
      i_wash_done = '0;
      tick();
      chk("t4_fall_no_clear", 32'(o_busy), 1);
      i_wash_done = 4'b0001;
      tick();
      chk("t4_second_edge_clear", 32'(o_busy), 0);

      // 5: credit saturation, then charge and coin in the same cycle
      do_reset();
      coins(30);
      chk("t5_credit30", 32'(o_credit), 30);
      chk("t5_not_full30", 32'(o_credit_full), 0);
      coins(1);
      chk("t5_credit31", 32'(o_credit), 31);
      chk("t5_full", 32'(o_credit_full), 1);
      coins(3);
      chk("t5_saturated", 32'(o_credit), 31);
      chk("t5_still_full", 32'(o_credit_full), 1);
      push(0, 1'b0, 30, -1);
      i_coin_pulse = 1'b1;
      i_req = 4'b0001;
      tick();
      tick();
      i_coin_pulse = 1'b0;
      wait_sb(10);
      i_req = '0;
      chk("t5_credit_after", 32'(o_credit), 30);
      chk("t5_full_after", 32'(o_credit_full), 0);

      // 6: reset during LAUNCH suppresses the start pulse and clears credit
      do_reset();
      coins(5);
      i_req = 4'b0010;
      tick();
      i_rst = 1'b1;
      #1;
      chk("t6_start", 32'(o_start), 0);
      chk("t6_busy", 32'(o_busy), 0);
      chk("t6_credit", 32'(o_credit), 0);
      chk("t6_full", 32'(o_credit_full), 0);
      chk("t6_double", 32'(o_double_wash), 0);
      repeat (3) tick();
      chk("t6_start_held_rst", 32'(o_start), 0);
      i_rst = 1'b0;
      i_req = '0;
      repeat (3) tick();
      chk("t6_busy_after", 32'(o_busy), 0);
      chk("t6_credit_after", 32'(o_credit), 0);

      if (sb.size() != 0) chk("scoreboard_leftover", 32'(sb.size()), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
